// File: rtl/dram_cmd_timer_if.sv
// Command bus between the DRAM controller FSM and the device-side timer.
// The controller holds cmd_req until it sees the one-cycle cmd_ack.
interface dram_cmd_timer_if #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
);
  logic                    cmd_req;
  logic [1:0]              cmd;
  logic [NUM_OF_BANKS-1:0] bank_sel;
  logic [NUM_OF_ROWS-1:0]  row_sel;
  logic [NUM_OF_COLS-1:0]  col_sel;
  logic                    cmd_ack;
  logic                    cmd_err;
  logic                    rd_strobe;
  logic                    wr_strobe;
  logic [NUM_OF_BANKS-1:0] bank_open;
  logic                    busy;

  modport master (
    output cmd_req, cmd, bank_sel, row_sel, col_sel,
    input  cmd_ack, cmd_err, rd_strobe, wr_strobe,
    input  bank_open, busy
  );

  modport slave (
    input  cmd_req, cmd, bank_sel, row_sel, col_sel,
    output cmd_ack, cmd_err, rd_strobe, wr_strobe,
    output bank_open, busy
  );
endinterface

// File: rtl/dram_cmd_timer.sv
// DRAM command acceptor: tracks per-bank open rows and enforces
// ACT/RD/WR/PRE/REFRESH latencies before returning a one-cycle ack.
module dram_cmd_timer #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 3,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 8
) (
  input logic             clk,
  input logic             rst,
  dram_cmd_timer_if.slave bus
);
  localparam int BW = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int RW = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
  localparam int TM1 = (T_RCD > T_CAS) ? T_RCD : T_CAS;
  localparam int TM2 = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
  localparam int CW = $clog2(TMAX + 1);

  localparam logic [1:0] C_ACT = 2'b00;
  localparam logic [1:0] C_RD  = 2'b01;
  localparam logic [1:0] C_WR  = 2'b10;
  localparam logic [1:0] C_PRE = 2'b11;

  typedef enum logic [2:0] {
    IDLE, DECODE, WAIT, ACK, DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [NUM_OF_BANKS-1:0] bsel_q, bsel_d;
  logic [NUM_OF_ROWS-1:0]  rsel_q, rsel_d;
  logic [NUM_OF_COLS-1:0]  csel_q, csel_d;
  logic [BW-1:0]           bidx_q, bidx_d;
  logic [RW-1:0]           ridx_q, ridx_d;
  logic                    bad_q, bad_d;
  logic [NUM_OF_BANKS-1:0] open_q, open_d;
  logic [RW-1:0]           rows_q [NUM_OF_BANKS];
  logic [RW-1:0]           rows_d [NUM_OF_BANKS];
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    refresh;
  logic [CW-1:0]           ld;

  function automatic logic [BW-1:0] enc_bank(
    input logic [NUM_OF_BANKS-1:0] v
  );
    logic [BW-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_OF_BANKS; i++)
      if (v[i]) e = BW'(i);
    return e;
  endfunction

  function automatic logic [RW-1:0] enc_row(
    input logic [NUM_OF_ROWS-1:0] v
  );
    logic [RW-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_OF_ROWS; i++)
      if (v[i]) e = RW'(i);
    return e;
  endfunction

  assign refresh = (cmd_q == C_PRE) && (&bsel_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    bsel_d  = bsel_q;
    rsel_d  = rsel_q;
    csel_d  = csel_q;
    bidx_d  = bidx_q;
    ridx_d  = ridx_q;
    bad_d   = bad_q;
    open_d  = open_q;
    rows_d  = rows_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    ld      = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_req) begin
          cmd_d   = bus.cmd;
          bsel_d  = bus.bank_sel;
          rsel_d  = bus.row_sel;
          csel_d  = bus.col_sel;
          bidx_d  = enc_bank(bus.bank_sel);
          ridx_d  = enc_row(bus.row_sel);
          state_d = DECODE;
        end
      end
      DECODE: begin
        bad_d = 1'b0;
        if (refresh) begin
          ld = CW'(T_RFC - 1);
        end else if (!$onehot(bsel_q)) begin
          bad_d = 1'b1;
        end else begin
          unique case (cmd_q)
            C_ACT: begin
              bad_d = !$onehot(rsel_q) || open_q[bidx_q];
              ld    = CW'(T_RCD - 1);
            end
            C_RD, C_WR: begin
              bad_d = !$onehot(csel_q) || !open_q[bidx_q];
              ld    = CW'(T_CAS - 1);
            end
            default: ld = CW'(T_RP - 1);
          endcase
        end
        if (bad_d) begin
          state_d = ACK;
        end else begin
          cnt_d   = ld;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          // Bank state commits as the command completes its timing window
          if (cmd_q == C_ACT) begin
            open_d[bidx_q] = 1'b1;
            rows_d[bidx_q] = ridx_q;
          end else if (refresh) begin
            open_d = '0;
          end else if (cmd_q == C_PRE) begin
            open_d[bidx_q] = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        ack_d   = 1'b1;
        err_d   = bad_q;
        rd_d    = !bad_q && (cmd_q == C_RD);
        wr_d    = !bad_q && (cmd_q == C_WR);
        state_d = DONE;
      end
      DONE: begin
        if (!bus.cmd_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      bsel_q  <= '0;
      rsel_q  <= '0;
      csel_q  <= '0;
      bidx_q  <= '0;
      ridx_q  <= '0;
      bad_q   <= 1'b0;
      open_q  <= '0;
      rows_q  <= '{default: '0};
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      bsel_q  <= bsel_d;
      rsel_q  <= rsel_d;
      csel_q  <= csel_d;
      bidx_q  <= bidx_d;
      ridx_q  <= ridx_d;
      bad_q   <= bad_d;
      open_q  <= open_d;
      rows_q  <= rows_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.cmd_ack   = ack_q;
  assign bus.cmd_err   = err_q;
  assign bus.rd_strobe = rd_q;
  assign bus.wr_strobe = wr_q;
  assign bus.bank_open = open_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
